cheri_tag_responder: RTL and testbench

Memory-side endpoint for the CHERI capability-tag sideband that the core drives on the data-user bits (TagWidth per capability granule). It accepts tagged write and read requests, keeps one tag per 16-byte capability granule of the cached region in an internal tag RAM, and returns the stored tag with each read response. It sits behind the AXI demux on the memory side and pairs with the core's tag-carrying load/store path.

---
 rtl/cheri_tag_responder_pkg.sv | 38 +++
 rtl/cheri_tag_responder_if.sv | 28 ++
 rtl/cheri_tag_responder_rsp_fifo.sv | 52 +++++
 rtl/cheri_tag_responder.sv | 133 +++++++++++++
 tb/tb_cheri_tag_responder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cheri_tag_responder_pkg.sv
// Shared types and geometry for the CHERI tag responder: request/response
// structs, FSM states and the address-to-granule mapping.
package cheri_tag_pkg;

  localparam int AddrWidth = 64;
  localparam int IdWidth   = 4;
  localparam int TagWidth  = 1;
  localparam int BeatBytes = 8;
  localparam int CapBytes  = 16;
  localparam int NumCaps   = 1024;
  localparam logic [AddrWidth-1:0] BaseAddr = 64'h8000_0000;

  localparam int IdxWidth = $clog2(NumCaps);
  localparam int CapShift = $clog2(CapBytes);

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   id;
    logic [BeatBytes-1:0] be;
    logic [TagWidth-1:0]  tag;
  } tag_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]  id;
    logic                we;
    logic [TagWidth-1:0] tag;
    logic                err;
  } tag_rsp_t;

  // Full-width granule number; callers range-check before truncating to IdxWidth.
  function automatic logic [AddrWidth-1:0] cap_index(input logic [AddrWidth-1:0] addr);
    return (addr - BaseAddr) >> CapShift;
  endfunction

endpackage

// File: rtl/cheri_tag_responder_if.sv
// Request/response handshake bundle between the memory-side demux and the tag responder.
interface cheri_tag_if;
  import cheri_tag_pkg::*;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [IdWidth-1:0]   req_id_i;
  logic [BeatBytes-1:0] req_be_i;
  logic [TagWidth-1:0]  req_tag_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [IdWidth-1:0]   rsp_id_o;
  logic                 rsp_we_o;
  logic [TagWidth-1:0]  rsp_tag_o;
  logic                 rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_id_i, req_be_i, req_tag_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_we_o, rsp_tag_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_id_i, req_be_i, req_tag_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_we_o, rsp_tag_o, rsp_err_o
  );
endinterface

// File: rtl/cheri_tag_responder_rsp_fifo.sv
// Two-entry response FIFO; the head is only valid when not empty (no fall-through).
module cheri_tag_rsp_fifo
  import cheri_tag_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  tag_rsp_t data_i,
  input  logic     pop_i,
  output tag_rsp_t data_o,
  output logic     full_o,
  output logic     empty_o,
  output logic [1:0] count_o
);

  tag_rsp_t   mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/cheri_tag_responder.sv
// Memory-side CHERI tag endpoint: one tag per 16-byte granule in an inline RAM,
// cleared by an INIT sweep after reset, answered in order with one-cycle latency.
module cheri_tag_responder
  import cheri_tag_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  cheri_tag_if.slave bus
);

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   init_cnt_q, init_cnt_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [IdWidth-1:0]    s1_id_q, s1_id_d;
  logic                  s1_we_q, s1_we_d;
  logic                  s1_err_q, s1_err_d;
  logic [TagWidth-1:0]   rd_tag_q;

  logic [TagWidth-1:0]   tag_ram_q [NumCaps];
  logic                  ram_we, ram_re;
  logic [IdxWidth-1:0]   ram_waddr;
  logic [TagWidth-1:0]   ram_wdata;

  tag_req_t              req;
  tag_rsp_t              s1_rsp, fifo_head;
  logic [AddrWidth-1:0]  gidx;
  logic [IdxWidth-1:0]   idx;
  logic                  in_range, accept, req_ready;
  logic                  rsp_valid, rsp_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]            fifo_cnt, outstanding;

  assign req = '{we: bus.req_we_i, addr: bus.req_addr_i, id: bus.req_id_i,
                 be: bus.req_be_i, tag: bus.req_tag_i};

  assign gidx     = cap_index(req.addr);
  assign idx      = gidx[IdxWidth-1:0];
  assign in_range = (req.addr >= BaseAddr) && (gidx < AddrWidth'(NumCaps));

  // Response path: S1 is shown directly when the FIFO is empty, otherwise the FIFO head.
  assign rsp_valid   = !fifo_empty || s1_vld_q;
  assign rsp_hs      = rsp_valid && bus.rsp_ready_i;
  assign fifo_pop    = rsp_hs && !fifo_empty;
  assign fifo_push   = s1_vld_q && !(fifo_empty && bus.rsp_ready_i);
  assign outstanding = fifo_cnt + {1'b0, s1_vld_q} - {1'b0, rsp_hs};
  assign accept      = bus.req_valid_i && req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt_q == IdxWidth'(NumCaps - 1)) state_d = RUN;
  end

  always_comb begin
    req_ready = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = init_cnt_q;
    ram_wdata = '0;
    if (state_q == INIT) begin
      ram_we = 1'b1;
    end else begin
      req_ready = (outstanding < 2'd2);
      ram_re    = accept && in_range && !req.we;
      ram_we    = accept && in_range && req.we && (|req.be);
      ram_waddr = idx;
      // A partial-beat write cannot carry a whole capability, so it invalidates the tag.
      ram_wdata = (&req.be) ? req.tag : '0;
    end
  end

  always_comb begin
    init_cnt_d = (state_q == INIT) ? init_cnt_q + IdxWidth'(1) : init_cnt_q;
    s1_vld_d   = accept;
    s1_id_d    = accept ? req.id    : s1_id_q;
    s1_we_d    = accept ? req.we    : s1_we_q;
    s1_err_d   = accept ? !in_range : s1_err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s1_we_q    <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      init_cnt_q <= init_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_id_q    <= s1_id_d;
      s1_we_q    <= s1_we_d;
      s1_err_q   <= s1_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) tag_ram_q[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       rd_tag_q <= '0;
    else if (ram_re) rd_tag_q <= tag_ram_q[idx];
  end

  assign s1_rsp = '{id: s1_id_q, we: s1_we_q, err: s1_err_q,
                    tag: (s1_we_q || s1_err_q) ? '0 : rd_tag_q};

  cheri_tag_rsp_fifo u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (s1_rsp),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = fifo_empty ? s1_rsp.id  : fifo_head.id;
  assign bus.rsp_we_o    = fifo_empty ? s1_rsp.we  : fifo_head.we;
  assign bus.rsp_tag_o   = fifo_empty ? s1_rsp.tag : fifo_head.tag;
  assign bus.rsp_err_o   = fifo_empty ? s1_rsp.err : fifo_head.err;

  // The two-entry bound on outstanding work is what keeps the FIFO from filling past two.
  full_no_s1_a: assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_full && s1_vld_q));

endmodule

// File: tb/tb_cheri_tag_responder.sv
// Directed bench for cheri_tag_responder: init sweep, tag set/clear, range errors,
// backpressure ordering and mid-flight reset.
module tb_cheri_tag_responder;

  logic clk = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  cheri_tag_if bus();

  cheri_tag_responder dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [63:0] addr, input logic [3:0] id,
                         input logic [7:0] be, input logic [0:0] tag);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_id_i    = id;
    bus.req_be_i    = be;
    bus.req_tag_i   = tag;
  endtask

  // One accepted request; returns at the following falling edge with valid dropped.
  task automatic xfer(input logic we, input logic [63:0] addr, input logic [3:0] id,
                      input logic [7:0] be, input logic [0:0] tag);
    set_req(we, addr, id, be, tag);
    chk("req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [3:0] id, input logic we,
                            input logic [0:0] tag, input logic err);
    chk({name, ".valid"}, {63'd0, bus.rsp_valid_o}, 64'd1);
    chk({name, ".id"},    {60'd0, bus.rsp_id_o},    {60'd0, id});
    chk({name, ".we"},    {63'd0, bus.rsp_we_o},    {63'd0, we});
    chk({name, ".tag"},   {63'd0, bus.rsp_tag_o},   {63'd0, tag});
    chk({name, ".err"},   {63'd0, bus.rsp_err_o},   {63'd0, err});
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (bus.req_ready_o !== 1'b1 && cyc < 1100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    set_req(1'b0, 64'h8000_0000, 4'hA, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst.req_ready", {63'd0, bus.req_ready_o}, 64'd0);
    chk("rst.rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("rst.rsp_id",    {60'd0, bus.rsp_id_o},    64'd0);
    chk("rst.rsp_we",    {63'd0, bus.rsp_we_o},    64'd0);
    chk("rst.rsp_tag",   {63'd0, bus.rsp_tag_o},   64'd0);
    chk("rst.rsp_err",   {63'd0, bus.rsp_err_o},   64'd0);

    rst_i = 1'b0;
    wait_init(n);
    chk("init_cycles", 64'(n), 64'd1024);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    expect_rsp("first_read", 4'hA, 1'b0, 1'b0, 1'b0);

    xfer(1'b1, 64'h8000_0010, 4'h3, 8'hFF, 1'b1);
    expect_rsp("wr_full", 4'h3, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 64'h8000_0018, 4'h5, 8'h00, 1'b0);
    expect_rsp("rd_after_wr", 4'h5, 1'b0, 1'b1, 1'b0);

    xfer(1'b1, 64'h8000_0010, 4'h1, 8'h0F, 1'b1);
    expect_rsp("wr_partial", 4'h1, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 64'h8000_0010, 4'h2, 8'h00, 1'b0);
    expect_rsp("rd_cleared", 4'h2, 1'b0, 1'b0, 1'b0);

    xfer(1'b1, 64'h8000_0010, 4'h4, 8'hFF, 1'b1);
    expect_rsp("wr_reset", 4'h4, 1'b1, 1'b0, 1'b0);
    xfer(1'b1, 64'h8000_0010, 4'h6, 8'h00, 1'b0);
    expect_rsp("wr_be0", 4'h6, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 64'h8000_0010, 4'h7, 8'h00, 1'b0);
    expect_rsp("rd_be0_kept", 4'h7, 1'b0, 1'b1, 1'b0);

    xfer(1'b0, 64'h7FFF_FFF0, 4'h8, 8'h00, 1'b0);
    expect_rsp("rd_below", 4'h8, 1'b0, 1'b0, 1'b1);
    xfer(1'b0, 64'h8000_4000, 4'h9, 8'h00, 1'b0);
    expect_rsp("rd_above", 4'h9, 1'b0, 1'b0, 1'b1);
    xfer(1'b1, 64'h8000_4000, 4'hB, 8'hFF, 1'b1);
    expect_rsp("wr_above", 4'hB, 1'b1, 1'b0, 1'b1);
    xfer(1'b0, 64'h8000_0000, 4'hC, 8'h00, 1'b0);
    expect_rsp("rd_no_alias", 4'hC, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 64'h8000_3FF8, 4'hE, 8'hFF, 1'b1);
    expect_rsp("wr_last", 4'hE, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 64'h8000_3FF0, 4'hF, 8'h00, 1'b0);
    expect_rsp("rd_last", 4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle.rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);

    // Backpressure: only two requests may be in flight.
    bus.rsp_ready_i = 1'b0;
    set_req(1'b0, 64'h8000_0010, 4'h1, 8'h00, 1'b0);
    chk("bp.ready0", {63'd0, bus.req_ready_o}, 64'd1);
    @(negedge clk);
    bus.req_id_i = 4'h2;
    chk("bp.ready1", {63'd0, bus.req_ready_o}, 64'd1);
    expect_rsp("bp.head0", 4'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.req_id_i = 4'h3;
    chk("bp.ready2", {63'd0, bus.req_ready_o}, 64'd0);
    expect_rsp("bp.hold1", 4'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp.ready3", {63'd0, bus.req_ready_o}, 64'd0);
    expect_rsp("bp.hold2", 4'h1, 1'b0, 1'b1, 1'b0);
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    expect_rsp("bp.drain2", 4'h2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp.empty", {63'd0, bus.rsp_valid_o}, 64'd0);

    // Reset with a full FIFO drops the responses and reruns the clear sweep.
    bus.rsp_ready_i = 1'b0;
    set_req(1'b0, 64'h8000_0010, 4'h5, 8'h00, 1'b0);
    @(negedge clk);
    bus.req_id_i = 4'h6;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("mid.ready_full", {63'd0, bus.req_ready_o}, 64'd0);
    chk("mid.valid_full", {63'd0, bus.rsp_valid_o}, 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid.rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    chk("mid.req_ready", {63'd0, bus.req_ready_o}, 64'd0);
    rst_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    set_req(1'b0, 64'h8000_0010, 4'hA, 8'h00, 1'b0);
    wait_init(n);
    chk("reinit_cycles", 64'(n), 64'd1024);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    expect_rsp("post_reset_rd", 4'hA, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
